// File: rtl/multicycle_ctrl.sv
// Multicycle processor control unit.
// Sequences FETCH -> DECODE -> EXEC -> (MEM) -> (WB) per instruction and
// drives the datapath strobes and mux selects for each step. Illegal
// opcodes park the unit in HALT until reset.
//
// Memory handshake: mem_read / mem_write act as the request (valid) and
// mem_ready is the completion (ready). A request is held asserted, and the
// FSM stays in its state, until the cycle in which mem_ready is 1; the
// access completes in that same cycle.
module multicycle_ctrl (
    input  logic        clk,
    input  logic        rst,
    input  logic [5:0]  opcode,
    input  logic        zero,
    input  logic        mem_ready,
    output logic        pc_write,
    output logic        ir_write,
    output logic        mem_read,
    output logic        mem_write,
    output logic        reg_write,
    output logic        reg_dst,
    output logic        alu_src,
    output logic        mem_to_reg,
    output logic [1:0]  pc_src,
    output logic [1:0]  alu_op,
    output logic [2:0]  state,
    output logic        halted,
    output logic        illegal,
    output logic [15:0] instr_count
);

    typedef enum logic [2:0] {
        S_FETCH  = 3'd0,
        S_DECODE = 3'd1,
        S_EXEC   = 3'd2,
        S_MEM    = 3'd3,
        S_WB     = 3'd4,
        S_HALT   = 3'd5
    } state_t;

    localparam logic [5:0] OP_R     = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_BNE   = 6'b000101;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_ADDIU = 6'b001001;
    localparam logic [5:0] OP_ANDI  = 6'b001100;
    localparam logic [5:0] OP_ORI   = 6'b001101;
    localparam logic [5:0] OP_J     = 6'b000010;

    state_t      state_q;
    state_t      state_d;
    logic [5:0]  op_q;
    logic        illegal_q;
    logic [15:0] count_q;
    logic        retire;

    function automatic logic is_supported(input logic [5:0] op);
        case (op)
            OP_R, OP_LW, OP_SW, OP_BEQ, OP_BNE,
            OP_ADDI, OP_ADDIU, OP_ANDI, OP_ORI, OP_J: is_supported = 1'b1;
            default:                                  is_supported = 1'b0;
        endcase
    endfunction

    // Next-state selection; unused codes 6/7 recover to FETCH.
    always_comb begin
        state_d = S_FETCH;
        case (state_q)
            S_FETCH:  state_d = mem_ready ? S_DECODE : S_FETCH;
            S_DECODE: state_d = is_supported(opcode) ? S_EXEC : S_HALT;
            S_EXEC: begin
                case (op_q)
                    OP_LW, OP_SW:                            state_d = S_MEM;
                    OP_R, OP_ADDI, OP_ADDIU, OP_ANDI, OP_ORI: state_d = S_WB;
                    default:                                 state_d = S_FETCH;
                endcase
            end
            S_MEM: begin
                if (!mem_ready)       state_d = S_MEM;
                else if (op_q == OP_LW) state_d = S_WB;
                else                  state_d = S_FETCH;
            end
            S_WB:    state_d = S_FETCH;
            S_HALT:  state_d = S_HALT;
            default: state_d = S_FETCH;
        endcase
    end

    // An instruction retires when control returns to FETCH from a later step.
    assign retire = (state_d == S_FETCH) &&
                    ((state_q == S_EXEC) || (state_q == S_MEM) || (state_q == S_WB));

    // State, captured opcode, illegal flag and retired-instruction counter.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= S_FETCH;
            op_q      <= 6'd0;
            illegal_q <= 1'b0;
            count_q   <= 16'd0;
        end else begin
            state_q <= state_d;
            if (state_q == S_DECODE) begin
                op_q <= opcode;
                if (!is_supported(opcode)) illegal_q <= 1'b1;
            end
            if (retire) count_q <= count_q + 16'd1;
        end
    end

    // Datapath controls; everything is held at 0 while rst is asserted.
    always_comb begin
        pc_write   = 1'b0;
        ir_write   = 1'b0;
        mem_read   = 1'b0;
        mem_write  = 1'b0;
        reg_write  = 1'b0;
        reg_dst    = 1'b0;
        alu_src    = 1'b0;
        mem_to_reg = 1'b0;
        pc_src     = 2'b00;
        alu_op     = 2'b00;
        if (!rst) begin
            case (state_q)
                S_FETCH: begin
                    mem_read = 1'b1;
                    if (mem_ready) begin
                        ir_write = 1'b1;
                        pc_write = 1'b1;
                        pc_src   = 2'b00;
                    end
                end
                S_EXEC: begin
                    case (op_q)
                        OP_R:              alu_op = 2'b10;
                        OP_ADDI, OP_ADDIU: alu_src = 1'b1;
                        OP_ANDI, OP_ORI: begin
                            alu_src = 1'b1;
                            alu_op  = 2'b11;
                        end
                        OP_LW, OP_SW:      alu_src = 1'b1;
                        OP_BEQ: begin
                            alu_op   = 2'b01;
                            pc_src   = 2'b01;
                            pc_write = zero;
                        end
                        OP_BNE: begin
                            alu_op   = 2'b01;
                            pc_src   = 2'b01;
                            pc_write = ~zero;
                        end
                        OP_J: begin
                            pc_src   = 2'b10;
                            pc_write = 1'b1;
                        end
                        default: ;
                    endcase
                end
                S_MEM: begin
                    if (op_q == OP_LW)      mem_read  = 1'b1;
                    else if (op_q == OP_SW) mem_write = 1'b1;
                end
                S_WB: begin
                    reg_write  = 1'b1;
                    reg_dst    = (op_q == OP_R);
                    mem_to_reg = (op_q == OP_LW);
                end
                default: ;
            endcase
        end
    end

    assign state       = state_q;
    assign halted      = (state_q == S_HALT);
    assign illegal     = illegal_q;
    assign instr_count = count_q;

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Directed bench for multicycle_ctrl: walks each instruction class cycle by
// cycle and compares state and the packed control word against hand-written
// expected values.
module tb_multicycle_ctrl;

    logic        clk;
    logic        rst;
    logic [5:0]  opcode;
    logic        zero;
    logic        mem_ready;
    logic        pc_write, ir_write, mem_read, mem_write, reg_write;
    logic        reg_dst, alu_src, mem_to_reg;
    logic [1:0]  pc_src, alu_op;
    logic [2:0]  state;
    logic        halted, illegal;
    logic [15:0] instr_count;

    // {pc_write, ir_write, mem_read, mem_write, reg_write,
    //  reg_dst, alu_src, mem_to_reg, pc_src[1:0], alu_op[1:0]}
    logic [11:0] ctl;
    assign ctl = {pc_write, ir_write, mem_read, mem_write, reg_write,
                  reg_dst, alu_src, mem_to_reg, pc_src, alu_op};

    localparam logic [11:0] C_NONE    = 12'b0000_0000_0000;
    localparam logic [11:0] C_F_RDY   = 12'b1110_0000_0000;
    localparam logic [11:0] C_F_WAIT  = 12'b0010_0000_0000;
    localparam logic [11:0] C_EX_R    = 12'b0000_0000_0010;
    localparam logic [11:0] C_EX_ADD  = 12'b0000_0010_0000;
    localparam logic [11:0] C_EX_LOG  = 12'b0000_0010_0011;
    localparam logic [11:0] C_EX_BR1  = 12'b1000_0000_0101;
    localparam logic [11:0] C_EX_BR0  = 12'b0000_0000_0101;
    localparam logic [11:0] C_EX_J    = 12'b1000_0000_1000;
    localparam logic [11:0] C_MEM_LW  = 12'b0010_0000_0000;
    localparam logic [11:0] C_MEM_SW  = 12'b0001_0000_0000;
    localparam logic [11:0] C_WB_R    = 12'b0000_1100_0000;
    localparam logic [11:0] C_WB_I    = 12'b0000_1000_0000;
    localparam logic [11:0] C_WB_LW   = 12'b0000_1001_0000;

    localparam logic [5:0] OP_R    = 6'b000000;
    localparam logic [5:0] OP_LW   = 6'b100011;
    localparam logic [5:0] OP_SW   = 6'b101011;
    localparam logic [5:0] OP_BEQ  = 6'b000100;
    localparam logic [5:0] OP_BNE  = 6'b000101;
    localparam logic [5:0] OP_ADDI = 6'b001000;
    localparam logic [5:0] OP_ANDI = 6'b001100;
    localparam logic [5:0] OP_ORI  = 6'b001101;
    localparam logic [5:0] OP_J    = 6'b000010;
    localparam logic [5:0] OP_BAD  = 6'b111111;

    int n_checks = 0;
    int n_errors = 0;
    logic [15:0] exp_count;

    multicycle_ctrl dut (
        .clk         (clk),
        .rst         (rst),
        .opcode      (opcode),
        .zero        (zero),
        .mem_ready   (mem_ready),
        .pc_write    (pc_write),
        .ir_write    (ir_write),
        .mem_read    (mem_read),
        .mem_write   (mem_write),
        .reg_write   (reg_write),
        .reg_dst     (reg_dst),
        .alu_src     (alu_src),
        .mem_to_reg  (mem_to_reg),
        .pc_src      (pc_src),
        .alu_op      (alu_op),
        .state       (state),
        .halted      (halted),
        .illegal     (illegal),
        .instr_count (instr_count)
    );

    // Clock: 10 time-unit period, rising edge active.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Called at posedge+1 with inputs already applied; checks this cycle,
    // then advances to just after the next rising edge.
    task automatic step(input string tag, input logic [2:0] exp_state, input logic [11:0] exp_ctl);
        #1;
        check({tag, "_state"}, 32'(state), 32'(exp_state));
        check({tag, "_ctl"}, 32'(ctl), 32'(exp_ctl));
        @(posedge clk);
        #1;
    endtask

    task automatic check_count(input string tag);
        check({tag, "_count"}, 32'(instr_count), 32'(exp_count));
    endtask

    initial begin
        rst       = 1'b1;
        opcode    = 6'd0;
        zero      = 1'b0;
        mem_ready = 1'b1;
        exp_count = 16'd0;

        // Reset: FETCH, no strobes even with mem_ready high.
        repeat (2) @(posedge clk);
        #1;
        check("rst_state", 32'(state), 32'd0);
        check("rst_ctl", 32'(ctl), 32'(C_NONE));
        check("rst_halted", 32'(halted), 32'd0);
        check("rst_illegal", 32'(illegal), 32'd0);
        check_count("rst");
        rst = 1'b0;

        // addi: 0,1,2,4 then back to FETCH.
        opcode = OP_ADDI;
        step("addi_f", 3'd0, C_F_RDY);
        step("addi_d", 3'd1, C_NONE);
        step("addi_e", 3'd2, C_EX_ADD);
        step("addi_w", 3'd4, C_WB_I);
        exp_count = 16'd1;
        check_count("addi");

        // R-type.
        opcode = OP_R;
        step("r_f", 3'd0, C_F_RDY);
        step("r_d", 3'd1, C_NONE);
        step("r_e", 3'd2, C_EX_R);
        step("r_w", 3'd4, C_WB_R);
        exp_count = 16'd2;
        check_count("r");

        // lw with three MEM wait cycles; mem_ready low in DECODE/EXEC is ignored.
        opcode = OP_LW;
        step("lw_f", 3'd0, C_F_RDY);
        mem_ready = 1'b0;
        step("lw_d", 3'd1, C_NONE);
        step("lw_e", 3'd2, C_EX_ADD);
        step("lw_m0", 3'd3, C_MEM_LW);
        step("lw_m1", 3'd3, C_MEM_LW);
        step("lw_m2", 3'd3, C_MEM_LW);
        mem_ready = 1'b1;
        step("lw_m3", 3'd3, C_MEM_LW);
        step("lw_w", 3'd4, C_WB_LW);
        exp_count = 16'd3;
        check_count("lw");

        // sw without wait states.
        opcode = OP_SW;
        step("sw_f", 3'd0, C_F_RDY);
        step("sw_d", 3'd1, C_NONE);
        step("sw_e", 3'd2, C_EX_ADD);
        step("sw_m", 3'd3, C_MEM_SW);
        exp_count = 16'd4;
        check_count("sw");

        // beq taken, bne with zero=1 (not taken), bne with zero=0 (taken).
        opcode = OP_BEQ;
        zero   = 1'b1;
        step("beq_f", 3'd0, C_F_RDY);
        step("beq_d", 3'd1, C_NONE);
        step("beq_e", 3'd2, C_EX_BR1);
        opcode = OP_BNE;
        step("bne1_f", 3'd0, C_F_RDY);
        step("bne1_d", 3'd1, C_NONE);
        step("bne1_e", 3'd2, C_EX_BR0);
        zero = 1'b0;
        step("bne0_f", 3'd0, C_F_RDY);
        step("bne0_d", 3'd1, C_NONE);
        step("bne0_e", 3'd2, C_EX_BR1);
        exp_count = 16'd7;
        check_count("branch");

        // j.
        opcode = OP_J;
        step("j_f", 3'd0, C_F_RDY);
        step("j_d", 3'd1, C_NONE);
        step("j_e", 3'd2, C_EX_J);
        exp_count = 16'd8;
        check_count("j");

        // andi with one FETCH wait, then ori.
        opcode    = OP_ANDI;
        mem_ready = 1'b0;
        step("andi_fw", 3'd0, C_F_WAIT);
        mem_ready = 1'b1;
        step("andi_f", 3'd0, C_F_RDY);
        step("andi_d", 3'd1, C_NONE);
        step("andi_e", 3'd2, C_EX_LOG);
        step("andi_w", 3'd4, C_WB_I);
        opcode = OP_ORI;
        step("ori_f", 3'd0, C_F_RDY);
        step("ori_d", 3'd1, C_NONE);
        step("ori_e", 3'd2, C_EX_LOG);
        step("ori_w", 3'd4, C_WB_I);
        exp_count = 16'd10;
        check_count("logic");

        // sw stalled in MEM, aborted by a reset pulse between edges.
        opcode = OP_SW;
        step("swr_f", 3'd0, C_F_RDY);
        step("swr_d", 3'd1, C_NONE);
        mem_ready = 1'b0;
        step("swr_e", 3'd2, C_EX_ADD);
        step("swr_m", 3'd3, C_MEM_SW);
        #2;
        rst = 1'b1;
        #1;
        check("swr_rst_state", 32'(state), 32'd0);
        check("swr_rst_memw", 32'(mem_write), 32'd0);
        exp_count = 16'd0;
        check_count("swr_rst");
        rst = 1'b0;
        @(posedge clk);
        #1;
        check("swr_after_state", 32'(state), 32'd0);
        check_count("swr_after");

        // Illegal opcode: HALT is sticky and silent until reset.
        opcode    = OP_BAD;
        mem_ready = 1'b1;
        step("bad_f", 3'd0, C_F_RDY);
        step("bad_d", 3'd1, C_NONE);
        check("bad_halted", 32'(halted), 32'd1);
        check("bad_illegal", 32'(illegal), 32'd1);
        opcode = OP_J;
        zero   = 1'b1;
        for (int i = 0; i < 10; i++) begin
            mem_ready = i[0];
            step("halt", 3'd5, C_NONE);
        end
        check("halt_halted", 32'(halted), 32'd1);
        check_count("halt");
        rst = 1'b1;
        #1;
        check("halt_rst_state", 32'(state), 32'd0);
        check("halt_rst_halted", 32'(halted), 32'd0);
        check("halt_rst_illegal", 32'(illegal), 32'd0);
        rst       = 1'b0;
        mem_ready = 1'b0;
        @(posedge clk);
        #1;

        // Counter wrap: preload 0xFFFF, one j retires to 0x0000.
        force dut.count_q = 16'hFFFF;
        #1;
        release dut.count_q;
        #1;
        check("wrap_preload", 32'(instr_count), 32'hFFFF);
        @(posedge clk);
        #1;
        mem_ready = 1'b1;
        opcode    = OP_J;
        zero      = 1'b0;
        step("wrap_f", 3'd0, C_F_RDY);
        step("wrap_d", 3'd1, C_NONE);
        step("wrap_e", 3'd2, C_EX_J);
        exp_count = 16'h0000;
        check_count("wrap");
        check("wrap_state", 32'(state), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
